spatial_encoder_mm: RTL and testbench

- Parametrised multimodal spatial encoder for the HD sensor-fusion pipeline. Sits between the input sample buffer and the temporal encoder.
- Per modality, for every channel c: binds the item-memory HV with the projection HV selected by the sign of that channel's feature.
- Takes the per-modality bitwise majority over channels, then the bitwise majority over the enabled modalities.
- Differences from the fixed 3-modality encoder: modality count, per-sample channel counts and a modality-enable mask are all configurable.

---
 rtl/hd_encoder_pkg.sv | 22 ++
 rtl/modality_accumulator.sv | 61 ++++++
 rtl/spatial_encoder_mm.sv | 161 ++++++++++++++++
 tb/tb_spatial_encoder_mm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_encoder_pkg.sv
// Shared types and helpers for the HD spatial encoder.
package hd_encoder_pkg;

  localparam int HV_DIM_DEFAULT = 2000;
  localparam int MAX_CH_DEFAULT = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINALIZE,
    S_OUTPUT
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/modality_accumulator.sv
// One modality: binds item-memory and sign-selected projection rows,
// counts ones per bit and thresholds the channel majority.
module modality_accumulator
  import hd_encoder_pkg::*;
#(
  parameter int HV_DIMENSION  = 16,
  parameter int CHANNEL_WIDTH = 8,
  parameter int CW            = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     step,
  input  logic                     first,
  input  logic                     second,
  input  logic [CHANNEL_WIDTH-1:0] feature,
  input  logic [CW-1:0]            cnt,
  input  logic [HV_DIMENSION-1:0]  im,
  input  logic [HV_DIMENSION-1:0]  proj_neg,
  input  logic [HV_DIMENSION-1:0]  proj_pos,
  output logic [HV_DIMENSION-1:0]  r
);

  logic                             neg, pos;
  logic [HV_DIMENSION-1:0]          proj, bound, tie;
  logic [HV_DIMENSION-1:0][CW-1:0]  bit_cnt;

  assign neg   = feature[CHANNEL_WIDTH-1];
  assign pos   = !neg && (|feature);
  assign bound = im ^ proj;

  // Projection chosen by feature sign; a zero feature binds with nothing.
  always_comb begin
    proj = '0;
    if (pos)      proj = proj_pos;
    else if (neg) proj = proj_neg;
  end

  // Per-bit ones counters and the even-count tie breaker (xor of first two rows).
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      bit_cnt <= '0;
      tie     <= '0;
    end else if (step) begin
      for (int b = 0; b < HV_DIMENSION; b++)
        bit_cnt[b] <= bit_cnt[b] + CW'(bound[b]);
      if (first)       tie <= bound;
      else if (second) tie <= tie ^ bound;
    end
  end

  // Channel majority: strict majority wins, exact half falls back to the tie bit.
  always_comb begin
    r = '0;
    for (int b = 0; b < HV_DIMENSION; b++) begin
      if ({bit_cnt[b], 1'b0} > {1'b0, cnt})       r[b] = 1'b1;
      else if ({bit_cnt[b], 1'b0} == {1'b0, cnt}) r[b] = tie[b];
    end
  end

endmodule

// File: rtl/spatial_encoder_mm.sv
// Multimodal spatial encoder: walks channels of every enabled modality in
// lock-step, then fuses the per-modality majorities into one hypervector.
module spatial_encoder_mm
  import hd_encoder_pkg::*;
#(
  parameter int HV_DIMENSION   = HV_DIM_DEFAULT,
  parameter int NUM_MODALITIES = 3,
  parameter int MAX_CHANNELS   = MAX_CH_DEFAULT,
  parameter int CHANNEL_WIDTH  = 8,
  localparam int CW = clog2(MAX_CHANNELS + 1),
  localparam int AW = (clog2(MAX_CHANNELS) > 0) ? clog2(MAX_CHANNELS) : 1
) (
  input  logic                                            Clk_CI,
  input  logic                                            Reset_RBI,
  input  logic                                            ValidIn_SI,
  output logic                                            ReadyOut_SO,
  input  logic [NUM_MODALITIES*MAX_CHANNELS*CHANNEL_WIDTH-1:0] ChannelsInput_DI,
  input  logic [NUM_MODALITIES*CW-1:0]                    ChanCount_DI,
  input  logic [NUM_MODALITIES-1:0]                       ModMask_DI,
  output logic [NUM_MODALITIES*AW-1:0]                    SramAddr_DO,
  input  logic [NUM_MODALITIES-1:0]                       SramValid_SI,
  input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]          IM_DI,
  input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]          ProjNeg_DI,
  input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]          ProjPos_DI,
  output logic [NUM_MODALITIES-1:0]                       ModActive_SO,
  output logic                                            ValidOut_SO,
  input  logic                                            ReadyIn_SI,
  output logic [HV_DIMENSION-1:0]                         HypervectorOut_DO
);

  localparam int MW = clog2(NUM_MODALITIES + 1);

  state_t state, state_n;

  logic [AW-1:0]                                             c;
  logic [NUM_MODALITIES-1:0][MAX_CHANNELS-1:0][CHANNEL_WIDTH-1:0] feat_q;
  logic [NUM_MODALITIES-1:0][CW-1:0]                         cnt_q;
  logic [NUM_MODALITIES-1:0]                                 en_q, en_in, act;
  logic [CW-1:0]                                             max_cnt;
  logic                                                      advance, last;
  logic [NUM_MODALITIES-1:0][HV_DIMENSION-1:0]               r_all;
  logic [HV_DIMENSION-1:0]                                   fused, low_r, hv_q;
  logic [MW-1:0]                                             n_en, ones;

  // A modality only takes part if it is unmasked and has at least one channel.
  always_comb begin
    en_in = '0;
    for (int m = 0; m < NUM_MODALITIES; m++)
      en_in[m] = ModMask_DI[m] && (ChanCount_DI[m*CW +: CW] != '0);
  end

  // Longest enabled modality sets how many rows the sample takes.
  always_comb begin
    max_cnt = '0;
    for (int m = 0; m < NUM_MODALITIES; m++)
      if (en_q[m] && (cnt_q[m] > max_cnt)) max_cnt = cnt_q[m];
  end

  // Modalities still reading rows, and the all-active-rows-ready advance.
  always_comb begin
    act = '0;
    for (int m = 0; m < NUM_MODALITIES; m++)
      act[m] = (state == S_LOAD) && en_q[m] && (CW'(c) < cnt_q[m]);
  end

  assign advance = (state == S_LOAD) && (&(SramValid_SI | ~act));
  assign last    = ({1'b0, CW'(c)} + (CW+1)'(1)) == {1'b0, max_cnt};

  assign ReadyOut_SO       = (state == S_IDLE);
  assign ValidOut_SO       = (state == S_OUTPUT);
  assign ModActive_SO      = act;
  assign SramAddr_DO       = {NUM_MODALITIES{c}};
  assign HypervectorOut_DO = hv_q;

  for (genvar m = 0; m < NUM_MODALITIES; m++) begin : g_mod
    modality_accumulator #(
      .HV_DIMENSION (HV_DIMENSION),
      .CHANNEL_WIDTH(CHANNEL_WIDTH),
      .CW           (CW)
    ) u_acc (
      .clk     (Clk_CI),
      .rst_n   (Reset_RBI),
      .clear   (state == S_IDLE),
      .step    (advance && act[m]),
      .first   (c == AW'(0)),
      .second  (c == AW'(1)),
      .feature (feat_q[m][c]),
      .cnt     (cnt_q[m]),
      .im      (IM_DI[m*HV_DIMENSION +: HV_DIMENSION]),
      .proj_neg(ProjNeg_DI[m*HV_DIMENSION +: HV_DIMENSION]),
      .proj_pos(ProjPos_DI[m*HV_DIMENSION +: HV_DIMENSION]),
      .r       (r_all[m])
    );
  end

  // Cross-modality majority; even split defers to the lowest enabled modality.
  always_comb begin
    n_en  = '0;
    low_r = '0;
    fused = '0;
    ones  = '0;
    for (int m = NUM_MODALITIES - 1; m >= 0; m--)
      if (en_q[m]) begin
        n_en  = n_en + MW'(1);
        low_r = r_all[m];
      end
    for (int b = 0; b < HV_DIMENSION; b++) begin
      ones = '0;
      for (int m = 0; m < NUM_MODALITIES; m++)
        ones = ones + MW'(r_all[m][b] & en_q[m]);
      if ({ones, 1'b0} > {1'b0, n_en})
        fused[b] = 1'b1;
      else if (({ones, 1'b0} == {1'b0, n_en}) && (n_en != '0))
        fused[b] = low_r[b];
    end
  end

  // State register.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) state <= S_IDLE;
    else            state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (ValidIn_SI) state_n = (|en_in) ? S_LOAD : S_FINALIZE;
      S_LOAD:     if (advance && last) state_n = S_FINALIZE;
      S_FINALIZE: state_n = S_OUTPUT;
      S_OUTPUT:   if (ReadyIn_SI) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Sample capture, channel counter and output register.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      c      <= '0;
      feat_q <= '0;
      cnt_q  <= '0;
      en_q   <= '0;
      hv_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          c <= '0;
          if (ValidIn_SI) begin
            feat_q <= ChannelsInput_DI;
            cnt_q  <= ChanCount_DI;
            en_q   <= en_in;
          end
        end
        S_LOAD:     if (advance && !last) c <= c + AW'(1);
        S_FINALIZE: hv_q <= fused;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_spatial_encoder_mm.sv
// Directed bench for spatial_encoder_mm: a table of hand-computed samples
// plus reset, stall and backpressure sequences.
module tb_spatial_encoder_mm;

  localparam int HV = 16;
  localparam int NM = 3;
  localparam int MC = 4;
  localparam int CHW = 4;
  localparam int CW = 3;
  localparam int AW = 2;

  logic              Clk_CI = 1'b0;
  logic              Reset_RBI;
  logic              ValidIn_SI;
  logic              ReadyOut_SO;
  logic [NM*MC*CHW-1:0] ChannelsInput_DI;
  logic [NM*CW-1:0]  ChanCount_DI;
  logic [NM-1:0]     ModMask_DI;
  logic [NM*AW-1:0]  SramAddr_DO;
  logic [NM-1:0]     SramValid_SI;
  logic [NM*HV-1:0]  IM_DI, ProjNeg_DI, ProjPos_DI;
  logic [NM-1:0]     ModActive_SO;
  logic              ValidOut_SO;
  logic              ReadyIn_SI;
  logic [HV-1:0]     HypervectorOut_DO;

  spatial_encoder_mm #(
    .HV_DIMENSION  (HV),
    .NUM_MODALITIES(NM),
    .MAX_CHANNELS  (MC),
    .CHANNEL_WIDTH (CHW)
  ) dut (
    .Clk_CI           (Clk_CI),
    .Reset_RBI        (Reset_RBI),
    .ValidIn_SI       (ValidIn_SI),
    .ReadyOut_SO      (ReadyOut_SO),
    .ChannelsInput_DI (ChannelsInput_DI),
    .ChanCount_DI     (ChanCount_DI),
    .ModMask_DI       (ModMask_DI),
    .SramAddr_DO      (SramAddr_DO),
    .SramValid_SI     (SramValid_SI),
    .IM_DI            (IM_DI),
    .ProjNeg_DI       (ProjNeg_DI),
    .ProjPos_DI       (ProjPos_DI),
    .ModActive_SO     (ModActive_SO),
    .ValidOut_SO      (ValidOut_SO),
    .ReadyIn_SI       (ReadyIn_SI),
    .HypervectorOut_DO(HypervectorOut_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic [NM-1:0]                mask;
    logic [NM-1:0][CW-1:0]        cnt;
    logic [NM-1:0][MC-1:0][CHW-1:0] feat;
    logic [NM-1:0][MC-1:0][HV-1:0]  im, pn, pp;
    logic [HV-1:0]                hv;
    int                           n;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  logic [NM-1:0][MC-1:0][HV-1:0] im_t, pn_t, pp_t;

  int n_chk = 0;
  int n_err = 0;

  // SRAM model: row contents follow the address the encoder presents.
  always_comb begin
    IM_DI      = '0;
    ProjNeg_DI = '0;
    ProjPos_DI = '0;
    for (int m = 0; m < NM; m++) begin
      IM_DI[m*HV +: HV]      = im_t[m][SramAddr_DO[m*AW +: AW]];
      ProjNeg_DI[m*HV +: HV] = pn_t[m][SramAddr_DO[m*AW +: AW]];
      ProjPos_DI[m*HV +: HV] = pp_t[m][SramAddr_DO[m*AW +: AW]];
    end
  end

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.mask = '0; v.cnt = '0; v.feat = '0;
    v.im = '0; v.pn = '0; v.pp = '0;
    v.hv = '0; v.n = 0;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    im_t = v.im; pn_t = v.pn; pp_t = v.pp;
    ChannelsInput_DI = v.feat;
    ChanCount_DI     = v.cnt;
    ModMask_DI       = v.mask;
  endtask

  // Accept a sample, measure latency to ValidOut, hold backpressure, drain.
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int lat;
    load_vec(v);
    check({tag, " ready_before"}, 32'(ReadyOut_SO), 32'd1);
    ValidIn_SI = 1'b1;
    tick();
    ValidIn_SI = 1'b0;
    lat = 0;
    while (!ValidOut_SO && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.n + 1));
    check({tag, " hv"}, 32'(HypervectorOut_DO), 32'(v.hv));
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, " bp_valid"}, 32'(ValidOut_SO), 32'd1);
      check({tag, " bp_hv"}, 32'(HypervectorOut_DO), 32'(v.hv));
      check({tag, " bp_ready"}, 32'(ReadyOut_SO), 32'd0);
    end
    ReadyIn_SI = 1'b1;
    tick();
    ReadyIn_SI = 1'b0;
    check({tag, " drained_valid"}, 32'(ValidOut_SO), 32'd0);
    check({tag, " drained_ready"}, 32'(ReadyOut_SO), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // single modality pass-through: 0x00FF ^ 0x0F0F
    vecs[0] = blank();
    vecs[0].mask = 3'b001; vecs[0].cnt[0] = 3'd1; vecs[0].feat[0][0] = 4'd3;
    vecs[0].im[0][0] = 16'h00FF; vecs[0].pp[0][0] = 16'h0F0F; vecs[0].pn[0][0] = 16'hFFFF;
    vecs[0].hv = 16'h0FF0; vecs[0].n = 1;
    // even count: bounds FFFF/0000 tie, xor breaks to 1
    vecs[1] = blank();
    vecs[1].mask = 3'b001; vecs[1].cnt[0] = 3'd2;
    vecs[1].feat[0][0] = 4'd1; vecs[1].im[0][0] = 16'h00FF; vecs[1].pp[0][0] = 16'hFF00;
    vecs[1].feat[0][1] = 4'hF; vecs[1].im[0][1] = 16'h1234; vecs[1].pn[0][1] = 16'h1234;
    vecs[1].pp[0][1] = 16'hFFFF;
    vecs[1].hv = 16'hFFFF; vecs[1].n = 2;
    // fusion tie between m0=AAAA (zero feature) and m1=5555; m2 masked
    vecs[2] = blank();
    vecs[2].mask = 3'b011; vecs[2].cnt = {3'd3, 3'd1, 3'd1};
    vecs[2].feat[0][0] = 4'd0; vecs[2].im[0][0] = 16'hAAAA; vecs[2].pp[0][0] = 16'hFFFF;
    vecs[2].pn[0][0] = 16'hFFFF;
    vecs[2].feat[1][0] = 4'hE; vecs[2].pn[1][0] = 16'h5555; vecs[2].pp[1][0] = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      vecs[2].feat[2][c] = 4'd1; vecs[2].im[2][c] = 16'hFFFF;
    end
    vecs[2].hv = 16'hAAAA; vecs[2].n = 1;
    // nothing enabled: straight to FINALIZE, zero output
    vecs[3] = blank();
    vecs[3].mask = 3'b000; vecs[3].cnt = {3'd1, 3'd1, 3'd1};
    vecs[3].feat[0][0] = 4'd1; vecs[3].im[0][0] = 16'hFFFF;
    vecs[3].hv = 16'h0000; vecs[3].n = 0;
    // unequal counts 3/1/2, all positive features, pp=0 so bound=IM
    vecs[4] = blank();
    vecs[4].mask = 3'b111; vecs[4].cnt = {3'd2, 3'd1, 3'd3};
    for (int m = 0; m < NM; m++)
      for (int c = 0; c < MC; c++) vecs[4].feat[m][c] = 4'd1;
    vecs[4].im[0][0] = 16'h000F; vecs[4].im[0][1] = 16'h00FF; vecs[4].im[0][2] = 16'h0F0F;
    vecs[4].im[1][0] = 16'h00F0;
    vecs[4].im[2][0] = 16'h0F00; vecs[4].im[2][1] = 16'h0FF0;
    vecs[4].hv = 16'h00F0; vecs[4].n = 3;
    // fusion tie resolved by m1 (lowest enabled); disabled m0 count ignored
    vecs[5] = blank();
    vecs[5].mask = 3'b110; vecs[5].cnt = {3'd1, 3'd1, 3'd2};
    vecs[5].feat[0][0] = 4'd1; vecs[5].im[0][0] = 16'hFFFF;
    vecs[5].feat[0][1] = 4'd1; vecs[5].im[0][1] = 16'hFFFF;
    vecs[5].feat[1][0] = 4'd1; vecs[5].pp[1][0] = 16'h3C3C;
    vecs[5].feat[2][0] = 4'hF; vecs[5].im[2][0] = 16'hFFFF; vecs[5].pn[2][0] = 16'h3C3C;
    vecs[5].hv = 16'h3C3C; vecs[5].n = 1;
    // full MAX_CHANNELS run with mixed signs and half-count ties
    vecs[6] = blank();
    vecs[6].mask = 3'b001; vecs[6].cnt[0] = 3'd4;
    vecs[6].feat[0] = {4'd0, 4'hF, 4'd1, 4'd1};
    vecs[6].im[0][0] = 16'hFFFF;
    vecs[6].pp[0][1] = 16'hFF00;
    vecs[6].im[0][2] = 16'hF0F0; vecs[6].pp[0][2] = 16'hFFFF;
    vecs[6].im[0][3] = 16'h8000; vecs[6].pp[0][3] = 16'hFFFF; vecs[6].pn[0][3] = 16'hFFFF;
    vecs[6].hv = 16'hF0F0; vecs[6].n = 4;
    // masked-in modality with zero channels is not enabled
    vecs[7] = blank();
    vecs[7].mask = 3'b100; vecs[7].cnt = {3'd0, 3'd2, 3'd2};
    vecs[7].feat[2][0] = 4'd1; vecs[7].im[2][0] = 16'hFFFF;
    vecs[7].hv = 16'h0000; vecs[7].n = 0;

    Reset_RBI = 1'b0; ValidIn_SI = 1'b0; ReadyIn_SI = 1'b0; SramValid_SI = 3'b111;
    load_vec(blank());
    tick(); tick();
    check("reset ready", 32'(ReadyOut_SO), 32'd1);
    check("reset valid", 32'(ValidOut_SO), 32'd0);
    check("reset hv", 32'(HypervectorOut_DO), 32'd0);
    check("reset active", 32'(ModActive_SO), 32'd0);
    Reset_RBI = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Reset mid-LOAD after two rows have accumulated.
    load_vec(vecs[6]);
    ValidIn_SI = 1'b1; tick(); ValidIn_SI = 1'b0;
    tick(); tick();
    check("midload addr", 32'(SramAddr_DO[1:0]), 32'd2);
    Reset_RBI = 1'b0;
    tick(); tick();
    check("midreset ready", 32'(ReadyOut_SO), 32'd1);
    check("midreset valid", 32'(ValidOut_SO), 32'd0);
    check("midreset hv", 32'(HypervectorOut_DO), 32'd0);
    check("midreset active", 32'(ModActive_SO), 32'd0);
    check("midreset addr", 32'(SramAddr_DO), 32'd0);
    Reset_RBI = 1'b1;
    tick();
    run_vec(vecs[6], 0, "post_reset");

    // SRAM stall: m1 not valid for three cycles while it is active.
    load_vec(vecs[4]);
    SramValid_SI = 3'b101;
    ValidIn_SI = 1'b1; tick(); ValidIn_SI = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall active", 32'(ModActive_SO), 32'b111);
      check("stall addr", 32'(SramAddr_DO), 32'd0);
      if (k < 2) tick();
    end
    SramValid_SI = 3'b111;
    tick();
    check("adv1 active", 32'(ModActive_SO), 32'b101);
    SramValid_SI = 3'b101;
    tick();
    check("adv2 active", 32'(ModActive_SO), 32'b001);
    check("adv2 addr", 32'(SramAddr_DO), 32'b101010);
    tick();
    check("finalize active", 32'(ModActive_SO), 32'd0);
    check("finalize valid", 32'(ValidOut_SO), 32'd0);
    tick();
    check("stall valid", 32'(ValidOut_SO), 32'd1);
    check("stall hv", 32'(HypervectorOut_DO), 32'h00F0);
    SramValid_SI = 3'b111;
    ReadyIn_SI = 1'b1; tick(); ReadyIn_SI = 1'b0;
    check("stall drained", 32'(ReadyOut_SO), 32'd1);

    // Backpressure: hold output for five cycles.
    run_vec(vecs[1], 5, "backpressure");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
